// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared parameters and state encoding for the ANN weight path
//
// Purpose: default geometry of one neuron's weight BRAM and the weight fetch
// controller state encoding, imported by every file of the weight path.
// Ports: none (package).

package ann_pkg;

  localparam int ANN_DEPTH = 28;  // weight words per neuron BRAM
  localparam int ANN_AW    = 5;   // BRAM address width
  localparam int ANN_DW    = 16;  // weight word width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FETCH   = 2'd2,
    DONE_ST = 2'd3
  } wf_state_t;

endpackage

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - loads a neuron weight BRAM and streams it to the MAC
//
// Purpose: in LOAD, writes incoming LOAD_VALID beats to addresses 0..DEPTH-1;
// in FETCH, reads addresses 0..DEPTH-1 from a negedge-clocked BRAM and presents
// them as a valid/ready weight stream, one word per cycle when W_READY is high.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   START, LOAD_START        fetch / load request pulses (honoured in IDLE only)
//   LOAD_VALID, LOAD_DATA    incoming weight words during LOAD
//   BRAM_ADDR/DI/EN/WE, DO   weight BRAM port (BRAM samples on negedge)
//   W_VALID/DATA/INDEX, W_READY  weight stream to the MAC
//   BUSY, DONE               not-idle flag, one-cycle completion pulse

module weight_fetch_ctrl
  import ann_pkg::*;
#(
  parameter int DEPTH = ANN_DEPTH,
  parameter int AW    = ANN_AW,
  parameter int DW    = ANN_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          LOAD_START,
  input  logic          LOAD_VALID,
  input  logic [DW-1:0] LOAD_DATA,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO,
  output logic          W_VALID,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  input  logic          W_READY,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  wf_state_t     state, state_n;
  logic [AW-1:0] rd_ptr, rd_n;
  logic [AW-1:0] wr_ptr, wr_n;
  logic          pending, pend_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] di_n;
  logic          en_n, we_n;
  logic          wv_n;
  logic [DW-1:0] wd_n;
  logic [AW-1:0] wi_n;
  logic          capture, handshake;

  // A word read at the previous edge may be taken once the output slot is free.
  assign capture   = pending && (!W_VALID || W_READY);
  assign handshake = W_VALID && W_READY;

  assign BUSY = (state != IDLE);
  assign DONE = (state == DONE_ST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pending   <= 1'b0;
      BRAM_ADDR <= '0;
      BRAM_DI   <= '0;
      BRAM_EN   <= 1'b0;
      BRAM_WE   <= 1'b0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      W_INDEX   <= '0;
    end else begin
      state     <= state_n;
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      pending   <= pend_n;
      BRAM_ADDR <= addr_n;
      BRAM_DI   <= di_n;
      BRAM_EN   <= en_n;
      BRAM_WE   <= we_n;
      W_VALID   <= wv_n;
      W_DATA    <= wd_n;
      W_INDEX   <= wi_n;
    end
  end

  always_comb begin
    state_n = state;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    pend_n  = pending;
    addr_n  = BRAM_ADDR;
    di_n    = BRAM_DI;
    en_n    = 1'b0;
    we_n    = 1'b0;
    wv_n    = W_VALID;
    wd_n    = W_DATA;
    wi_n    = W_INDEX;

    unique case (state)
      IDLE: begin
        if (LOAD_START) begin
          state_n = LOAD;
          wr_n    = '0;
        end else if (START) begin
          state_n = FETCH;
          rd_n    = '0;
          pend_n  = 1'b0;
        end
      end

      LOAD: begin
        if (LOAD_VALID) begin
          addr_n = wr_ptr;
          di_n   = LOAD_DATA;
          en_n   = 1'b1;
          we_n   = 1'b1;
          if (wr_ptr == LAST) state_n = DONE_ST;
          else                wr_n    = wr_ptr + 1'b1;
        end
      end

      FETCH: begin
        en_n   = 1'b1;
        addr_n = rd_ptr;
        // BRAM_EN is still low on the first FETCH edge: issue address 0 there.
        if (!BRAM_EN) pend_n = 1'b1;
        if (handshake) wv_n = 1'b0;
        if (capture) begin
          wv_n = 1'b1;
          wd_n = BRAM_DO;
          wi_n = rd_ptr;
          if (rd_ptr != LAST) begin
            rd_n   = rd_ptr + 1'b1;
            addr_n = rd_ptr + 1'b1;
          end else begin
            pend_n = 1'b0;
          end
        end
        if (handshake && W_INDEX == LAST) begin
          state_n = DONE_ST;
          en_n    = 1'b0;
        end
      end

      DONE_ST: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb/tb_weight_fetch_ctrl.sv - directed self-checking bench for weight_fetch_ctrl

module tb_weight_fetch_ctrl;
  import ann_pkg::*;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START, LOAD_START, LOAD_VALID, W_READY;
  logic [DW-1:0] LOAD_DATA;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI;
  logic          BRAM_EN, BRAM_WE;
  logic [DW-1:0] BRAM_DO;
  logic          W_VALID;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] W_INDEX;
  logic          BUSY, DONE;

  int checks = 0;
  int errors = 0;

  weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LOAD_START(LOAD_START),
    .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DO(BRAM_DO), .W_VALID(W_VALID), .W_DATA(W_DATA), .W_INDEX(W_INDEX),
    .W_READY(W_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Negedge-clocked weight BRAM model with a write counter.
  logic [DW-1:0] mem [DEPTH];
  int wcount = 0;
  always @(negedge CLK) begin
    if (BRAM_EN && int'(BRAM_ADDR) < DEPTH) begin
      if (BRAM_WE) begin
        mem[BRAM_ADDR] <= BRAM_DI;
        wcount <= wcount + 1;
      end
      BRAM_DO <= mem[BRAM_ADDR];
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick;
    tick;
    checks++;
    if ({W_VALID, W_DATA, W_INDEX} !== '0) begin
      errors++;
      $display("FAIL reset_stream: got valid=%b data=%0d index=%0d, want all 0", W_VALID, W_DATA, W_INDEX);
    end
    checks++;
    if ({BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE} !== '0) begin
      errors++;
      $display("FAIL reset_bram: got addr=%0d di=%0d en=%b we=%b, want all 0", BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE);
    end
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b, want 0 0", BUSY, DONE);
    end
    RST = 1'b0;
    tick;
    checks++;
    if (BUSY !== 1'b0 || BRAM_EN !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b en=%b, want 0 0", BUSY, BRAM_EN);
    end
  endtask

  task automatic test_load(input int nbeats, input bit with_start, input string name);
    int w0;
    w0 = wcount;
    LOAD_START = 1'b1;
    START = with_start;
    tick;
    LOAD_START = 1'b0;
    START = 1'b0;
    tick;
    checks++;
    if (BRAM_EN !== 1'b0 || BRAM_WE !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s_enter_load: got en=%b we=%b busy=%b, want 0 0 1", name, BRAM_EN, BRAM_WE, BUSY);
    end
    for (int i = 0; i < nbeats; i++) begin
      LOAD_VALID = 1'b1;
      LOAD_DATA = DW'(i + 100);
      tick;
      checks++;
      if (i < DEPTH) begin
        if (BRAM_WE !== 1'b1 || BRAM_EN !== 1'b1 || int'(BRAM_ADDR) != i || int'(BRAM_DI) != i + 100) begin
          errors++;
          $display("FAIL %s_write_%0d: got en=%b we=%b addr=%0d di=%0d, want 1 1 %0d %0d",
                   name, i, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, i, i + 100);
        end
      end else begin
        if (BRAM_WE !== 1'b0 || BRAM_EN !== 1'b0) begin
          errors++;
          $display("FAIL %s_extra_beat_%0d: got en=%b we=%b, want 0 0", name, i, BRAM_EN, BRAM_WE);
        end
      end
      if (i == DEPTH - 1) begin
        checks++;
        if (DONE !== 1'b1) begin
          errors++;
          $display("FAIL %s_done_pulse: got done=%b, want 1", name, DONE);
        end
      end
      if (i == DEPTH) begin
        checks++;
        if (DONE !== 1'b0) begin
          errors++;
          $display("FAIL %s_done_single: got done=%b, want 0", name, DONE);
        end
      end
    end
    LOAD_VALID = 1'b0;
    tick;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || BRAM_WE !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_idle: got done=%b busy=%b we=%b, want 0 0 0", name, DONE, BUSY, BRAM_WE);
    end
    checks++;
    if (wcount - w0 != DEPTH) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, want %0d", name, wcount - w0, DEPTH);
    end
    checks++;
    if (mem[DEPTH-1] !== 16'd127 || mem[0] !== 16'd100) begin
      errors++;
      $display("FAIL %s_mem_contents: got mem[0]=%0d mem[27]=%0d, want 100 127", name, mem[0], mem[DEPTH-1]);
    end
  endtask

  task automatic test_fetch(input int stall_lo, input int stall_hi, input bit start_mid, input string name);
    int n, exp_idx, first_valid, done_n, stall_len, we_bad;
    bit held;
    logic [DW-1:0] hd;
    logic [AW-1:0] hx;
    stall_len = (stall_hi >= stall_lo) ? stall_hi - stall_lo + 1 : 0;
    W_READY = 1'b1;
    START = 1'b1;
    tick;
    START = 1'b0;
    n = 0;
    exp_idx = 0;
    first_valid = -1;
    done_n = -1;
    we_bad = 0;
    held = 1'b0;
    hd = '0;
    hx = '0;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, want 1", name, BUSY);
    end
    while (n < 100) begin
      W_READY = !(n >= stall_lo && n <= stall_hi);
      START = start_mid && (n == 10);
      if (DONE === 1'b1) begin
        done_n = n;
        break;
      end
      if (BRAM_WE !== 1'b0) we_bad++;
      if (held) begin
        checks++;
        if (W_VALID !== 1'b1 || W_DATA !== hd || W_INDEX !== hx) begin
          errors++;
          $display("FAIL %s_hold_c%0d: got valid=%b data=%0d index=%0d, want 1 %0d %0d",
                   name, n, W_VALID, W_DATA, W_INDEX, hd, hx);
        end
      end
      if (W_VALID === 1'b1 && first_valid < 0) first_valid = n;
      held = 1'b0;
      if (W_VALID === 1'b1) begin
        if (W_READY) begin
          checks++;
          if (int'(W_INDEX) != exp_idx || int'(W_DATA) != exp_idx + 100) begin
            errors++;
            $display("FAIL %s_word_%0d: got index=%0d data=%0d, want %0d %0d",
                     name, exp_idx, W_INDEX, W_DATA, exp_idx, exp_idx + 100);
          end
          exp_idx++;
        end else begin
          held = 1'b1;
          hd = W_DATA;
          hx = W_INDEX;
        end
      end
      tick;
      n++;
    end
    START = 1'b0;
    W_READY = 1'b1;
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL %s_first_valid: got cycle %0d, want 2", name, first_valid);
    end
    checks++;
    if (exp_idx != DEPTH) begin
      errors++;
      $display("FAIL %s_handshakes: got %0d, want %0d", name, exp_idx, DEPTH);
    end
    checks++;
    if (done_n != 30 + stall_len) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d, want %0d", name, done_n, 30 + stall_len);
    end
    checks++;
    if (BRAM_EN !== 1'b0 || we_bad != 0) begin
      errors++;
      $display("FAIL %s_bram_ctl: got en_at_done=%b we_cycles=%0d, want 0 0", name, BRAM_EN, we_bad);
    end
    tick;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || W_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b busy=%b valid=%b, want 0 0 0", name, DONE, BUSY, W_VALID);
    end
  endtask

  task automatic test_reset_mid_fetch;
    int n;
    W_READY = 1'b1;
    START = 1'b1;
    tick;
    START = 1'b0;
    n = 0;
    while (!(W_VALID === 1'b1 && W_INDEX == 5'd10) && n < 60) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL abort_reach_idx10: got timeout after %0d cycles, want index 10", n);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({W_VALID, W_DATA, W_INDEX, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE, DONE, BUSY} !== '0) begin
      errors++;
      $display("FAIL abort_async_clear: got valid=%b data=%0d index=%0d addr=%0d di=%0d en=%b we=%b done=%b busy=%b, want all 0",
               W_VALID, W_DATA, W_INDEX, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE, DONE, BUSY);
    end
    tick;
    tick;
    RST = 1'b0;
    tick;
    tick;
    checks++;
    if (BUSY !== 1'b0 || BRAM_EN !== 1'b0 || W_VALID !== 1'b0) begin
      errors++;
      $display("FAIL abort_stays_idle: got busy=%b en=%b valid=%b, want 0 0 0", BUSY, BRAM_EN, W_VALID);
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    LOAD_START = 1'b0;
    LOAD_VALID = 1'b0;
    LOAD_DATA = '0;
    W_READY = 1'b0;
    test_reset;
    test_load(DEPTH, 1'b0, "load");
    test_fetch(-1, -2, 1'b0, "fetch");
    test_fetch(3, 6, 1'b0, "stall");
    test_load(DEPTH, 1'b1, "both_start");
    test_fetch(-1, -2, 1'b1, "start_ignored");
    test_reset_mid_fetch;
    test_fetch(-1, -2, 1'b0, "restart");
    test_load(30, 1'b0, "extra_beats");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
